sr_latch_monitor: RTL

SR_LATCH_MONITOR -- requirements
Module: sr_latch_monitor

---
 rtl/sr_latch_monitor_if.sv | 15 +
 rtl/sr_latch_monitor.sv | 103 ++++++++++
 2 files changed

// File: rtl/sr_latch_monitor_if.sv
// sr_latch_monitor_if: observed latch controls/outputs in, monitor verdicts out.
interface sr_latch_monitor_if #(parameter int CNT_W = 8);
    logic             s, r, enable, q, qn, clear;
    logic             exp_q, exp_valid, mismatch, forbidden, forbidden_seen;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;
    modport master (
        output s, r, enable, q, qn, clear,
        input  exp_q, exp_valid, mismatch, forbidden, forbidden_seen, err_count, state
    );
    modport slave (
        input  s, r, enable, q, qn, clear,
        output exp_q, exp_valid, mismatch, forbidden, forbidden_seen, err_count, state
    );
endinterface

// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor: models an SR latch from its registered controls and flags output errors.
module sr_latch_monitor #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 2
) (
    input logic              clk,
    input logic              rst_n,
    sr_latch_monitor_if.slave bus
);
    typedef enum logic [1:0] {UNKNOWN, STABLE, SETTLING, INVALID} state_t;
    localparam logic [3:0]       LOAD = 4'(SETTLE);
    localparam logic [CNT_W-1:0] MAX  = '1;
    state_t           r_state, w_state;
    logic             r_s, r_r, r_en, r_q, r_qn;
    logic             r_exp_q, w_exp_q, r_exp_valid;
    logic             r_mismatch, w_mismatch, r_forbidden, w_forbidden, r_fseen;
    logic [3:0]       r_cnt, w_cnt;
    logic [CNT_W-1:0] r_err;
    logic             w_set, w_rst, w_forb, w_cmd, w_chg, w_ok;
    assign w_set  = r_en & r_s & ~r_r;
    assign w_rst  = r_en & ~r_s & r_r;
    assign w_forb = r_en & r_s & r_r;
    assign w_cmd  = w_set | w_rst;
    assign w_chg  = w_cmd && (w_set != r_exp_q);
    assign w_ok   = (r_q == r_exp_q) && (r_qn == ~r_exp_q);
    always_comb begin
        w_state     = r_state;
        w_exp_q     = r_exp_q;
        w_cnt       = r_cnt;
        w_mismatch  = 1'b0;
        w_forbidden = 1'b0;
        if (w_forb) begin
            w_state     = INVALID;
            w_forbidden = r_state != INVALID;
            w_mismatch  = r_state == STABLE && !w_ok;
        end else begin
            case (r_state)
                UNKNOWN, INVALID: begin
                    if (w_cmd) begin
                        w_state = SETTLING;
                        w_exp_q = w_set;
                        w_cnt   = LOAD;
                    end else if (r_state == INVALID) begin
                        w_state = UNKNOWN;
                    end
                end
                STABLE: begin
                    w_mismatch = !w_ok;
                    if (w_chg) begin
                        w_state = SETTLING;
                        w_exp_q = w_set;
                        w_cnt   = LOAD;
                    end
                end
                default: begin
                    // a fresh target restarts the settle window
                    if (w_chg) begin
                        w_exp_q = w_set;
                        w_cnt   = LOAD;
                    end else if (w_ok) begin
                        w_state = STABLE;
                    end else if (r_cnt <= 4'd1) begin
                        w_state    = STABLE;
                        w_mismatch = 1'b1;
                        w_cnt      = 4'd0;
                    end else begin
                        w_cnt = r_cnt - 4'd1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_s, r_r, r_en, r_q, r_qn} <= '0;
            r_state     <= UNKNOWN;
            r_exp_q     <= 1'b0;
            r_exp_valid <= 1'b0;
            r_cnt       <= '0;
            r_mismatch  <= 1'b0;
            r_forbidden <= 1'b0;
            r_fseen     <= 1'b0;
            r_err       <= '0;
        end else begin
            {r_s, r_r, r_en, r_q, r_qn} <= {bus.s, bus.r, bus.enable, bus.q, bus.qn};
            r_state     <= w_state;
            r_exp_q     <= w_exp_q;
            r_exp_valid <= w_state == STABLE || w_state == SETTLING;
            r_cnt       <= w_cnt;
            r_mismatch  <= w_mismatch;
            r_forbidden <= w_forbidden;
            r_fseen     <= bus.clear ? 1'b0 : r_fseen | w_forbidden;
            r_err       <= bus.clear ? '0 : r_err + CNT_W'(w_mismatch && r_err != MAX);
        end
    end
    assign bus.exp_q          = r_exp_q;
    assign bus.exp_valid      = r_exp_valid;
    assign bus.mismatch       = r_mismatch;
    assign bus.forbidden      = r_forbidden;
    assign bus.forbidden_seen = r_fseen;
    assign bus.err_count      = r_err;
    assign bus.state          = r_state;
endmodule
